counter_sram_responder: RTL and testbench

- Synthesizable stand-in for the external addressing and storage path: a 12-bit ripple-counter equivalent (MC14040B behaviour) feeding a word-wide SRAM (IDT71V016SA-style, CS/OE/BLE/BHE tied low, WE_BAR selects read/write).
- Sits opposite the SRAM/counter demo controller, on-FPGA or in a second board's fabric. Lets the controller's write/read/verify flow run without the external ICs and exposes protocol errors.

---
 rtl/sram_demo_pkg.sv | 15 +
 rtl/sync_edge_det.sv | 38 +++
 rtl/counter_sram_responder.sv | 188 ++++++++++++++++++
 tb/tb_counter_sram_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_demo_pkg.sv
// Shared constants for the SRAM/counter demo responder: default widths,
// synchronizer depth and responder FSM state encodings.
package sram_demo_pkg;

  localparam int CNT_W_DEF   = 12;
  localparam int DW_DEF      = 16;
  localparam int SYNC_STAGES = 2;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_READ_WAIT  = 3'd1;
  localparam logic [2:0] ST_READ_DRIVE = 3'd2;
  localparam logic [2:0] ST_WRITE      = 3'd3;
  localparam logic [2:0] ST_TURN       = 3'd4;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses
// derived from the synchronized level and its registered previous value.
module sync_edge_det
  import sram_demo_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev_q;
  assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/counter_sram_responder.sv
// Stand-in for the external MC14040B counter plus word-wide SRAM seen by the demo
// controller. Optional read fault injection at FAULT_ADDR: SRAM_RESP_FAULT_INJ_EN.
module counter_sram_responder
  import sram_demo_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int READ_LAT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CNT_CLK_IN,
  input  logic             CNT_RST_IN,
  input  logic             WE_BAR_IN,
  input  logic [DW-1:0]    DATA_IN,
  output logic [DW-1:0]    DATA_OUT,
  output logic             DATA_OE,
  output logic [CNT_W-1:0] COUNT_OUT,
  output logic             PROTO_ERR,
  output logic [15:0]      WR_COUNT,
  input  logic [CNT_W-1:0] FAULT_ADDR
);

  // DEPTH is a power of two: the low counter bits form the address.
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(READ_LAT + 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(READ_LAT - 1);
  localparam logic [2:0]    SYNC_IDLE = 3'b100;

  logic [2:0] pin_vec, sync_s, rise_s, fall_s;
  logic       cnt_fall, cnt_rst_s, we_s, we_rise;

  assign pin_vec = {WE_BAR_IN, CNT_RST_IN, CNT_CLK_IN};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      sync_edge_det #(
        .RST_VAL (SYNC_IDLE[gi])
      ) u_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (pin_vec[gi]),
        .sync_out (sync_s[gi]),
        .rise     (rise_s[gi]),
        .fall     (fall_s[gi])
      );
    end
  endgenerate

  assign cnt_fall  = fall_s[0];
  assign cnt_rst_s = sync_s[1];
  assign we_s      = sync_s[2];
  assign we_rise   = rise_s[2];

  logic unused_sync;
  assign unused_sync = ^{sync_s[0], rise_s[1:0], fall_s[2:1]};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       state_q, state_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [1:0]       low_q, low_d;
  logic [DW-1:0]    hold_q, hold_d;
  logic [DW-1:0]    rd_q, rd_d, rd_raw;
  logic             err_q, err_d;
  logic [15:0]      wrc_q, wrc_d;
  logic             cnt_chg, glitch, commit;
  logic [AW-1:0]    addr;

  logic [DW-1:0] mem [DEPTH];

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_rst_s) begin
      cnt_d = '0;
    end else if (cnt_fall) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign cnt_chg = (cnt_d != cnt_q);
  assign addr    = cnt_q[AW-1:0];

  // Low-phase width of the synchronized write enable, saturating at 3.
  always_comb begin
    low_d = 2'd0;
    if (!we_s) begin
      low_d = (low_q == 2'd3) ? low_q : low_q + 2'd1;
    end
  end

  assign glitch = we_rise && (low_q < 2'd2);
  assign commit = (state_q == ST_WRITE) && we_rise && !glitch;

  always_comb begin
    state_d = state_q;
    lat_d   = '0;
    case (state_q)
      ST_IDLE: begin
        state_d = we_s ? ST_READ_WAIT : ST_WRITE;
      end
      ST_READ_WAIT: begin
        lat_d = lat_q;
        if (!we_s) begin
          state_d = ST_WRITE;
        end else if (cnt_chg) begin
          lat_d = '0;
        end else if (lat_q == LAT_LAST) begin
          state_d = ST_READ_DRIVE;
          lat_d   = '0;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_READ_DRIVE: begin
        if (!we_s) begin
          state_d = ST_TURN;
        end else if (cnt_chg) begin
          state_d = ST_READ_WAIT;
        end
      end
      ST_TURN: begin
        state_d = we_s ? ST_READ_WAIT : ST_WRITE;
      end
      ST_WRITE: begin
        if (we_s) begin
          state_d = ST_READ_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_raw = mem[addr];
`ifdef SRAM_RESP_FAULT_INJ_EN
    if (cnt_q == FAULT_ADDR) begin
      rd_raw[0] = ~rd_raw[0];
    end
`endif
    rd_d   = ((state_q == ST_READ_WAIT) || (state_q == ST_READ_DRIVE)) ? rd_raw : rd_q;
    hold_d = (state_q == ST_WRITE) ? DATA_IN : hold_q;
    err_d  = err_q | glitch | ((state_q == ST_WRITE) && (cnt_chg || cnt_rst_s));
    wrc_d  = (commit && (wrc_q != 16'hFFFF)) ? wrc_q + 16'd1 : wrc_q;
  end

`ifndef SRAM_RESP_FAULT_INJ_EN
  logic unused_fault;
  assign unused_fault = ^FAULT_ADDR;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q   <= '0;
      state_q <= ST_IDLE;
      lat_q   <= '0;
      low_q   <= 2'd0;
      hold_q  <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      wrc_q   <= 16'd0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      lat_q   <= lat_d;
      low_q   <= low_d;
      hold_q  <= hold_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      wrc_q   <= wrc_d;
    end
  end

  // Storage is deliberately outside reset so contents survive RST.
  always_ff @(posedge CLK) begin
    if (commit && !RST) begin
      mem[addr] <= hold_q;
    end
  end

  // Drive enable follows next state so the bus is released as soon as we_s falls.
  assign DATA_OE   = (state_q == ST_READ_DRIVE) && (state_d == ST_READ_DRIVE);
  assign DATA_OUT  = rd_q;
  assign COUNT_OUT = cnt_q;
  assign PROTO_ERR = err_q;
  assign WR_COUNT  = wrc_q;

endmodule

// File: tb/tb_counter_sram_responder.sv
// Directed bench for counter_sram_responder: write/readback, counter wrap and
// aliasing, bus turnaround, protocol errors and optional read fault injection.
module tb_counter_sram_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CNT_CLK_IN, CNT_RST_IN, WE_BAR_IN;
  logic [15:0] DATA_IN;
  logic [15:0] DATA_OUT;
  logic        DATA_OE;
  logic [11:0] COUNT_OUT;
  logic        PROTO_ERR;
  logic [15:0] WR_COUNT;
  logic [11:0] FAULT_ADDR;

  int n_tests = 0;
  int n_fail  = 0;

  counter_sram_responder dut (
    .CLK        (CLK),
    .RST        (RST),
    .CNT_CLK_IN (CNT_CLK_IN),
    .CNT_RST_IN (CNT_RST_IN),
    .WE_BAR_IN  (WE_BAR_IN),
    .DATA_IN    (DATA_IN),
    .DATA_OUT   (DATA_OUT),
    .DATA_OE    (DATA_OE),
    .COUNT_OUT  (COUNT_OUT),
    .PROTO_ERR  (PROTO_ERR),
    .WR_COUNT   (WR_COUNT),
    .FAULT_ADDR (FAULT_ADDR)
  );

  always #5 CLK = ~CLK;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic cnt_pulse(input int hi, input int lo);
    CNT_CLK_IN = 1'b1;
    cyc(hi);
    CNT_CLK_IN = 1'b0;
    cyc(lo);
  endtask

  task automatic cnt_clear();
    CNT_RST_IN = 1'b1;
    cyc(4);
    CNT_RST_IN = 1'b0;
    cyc(4);
  endtask

  task automatic do_write(input logic [15:0] d);
    DATA_IN   = d;
    WE_BAR_IN = 1'b0;
    cyc(4);
    WE_BAR_IN = 1'b1;
    cyc(6);
    $display("[TB] write count=%0d data=%h", COUNT_OUT, d);
  endtask

  task automatic wait_oe(output bit ok);
    int k;
    ok = 1'b0;
    k  = 0;
    while (!ok && k < 20) begin
      if (DATA_OE) ok = 1'b1;
      else begin
        cyc(1);
        k++;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cyc(3);
    n_tests++;
    if (DATA_OUT !== 16'h0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0000", DATA_OUT); end
    n_tests++;
    if (DATA_OE !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b expected 0", DATA_OE); end
    n_tests++;
    if (COUNT_OUT !== 12'h0) begin n_fail++; $display("FAIL reset_count: got %h expected 000", COUNT_OUT); end
    n_tests++;
    if (PROTO_ERR !== 1'b0) begin n_fail++; $display("FAIL reset_proto_err: got %b expected 0", PROTO_ERR); end
    n_tests++;
    if (WR_COUNT !== 16'h0) begin n_fail++; $display("FAIL reset_wr_count: got %h expected 0000", WR_COUNT); end
    RST = 1'b0;
    cyc(2);
  endtask

  task automatic test_write_readback();
    bit ok;
    int lat;
    bit seen_low;
    cnt_clear();
    for (int i = 0; i < 16; i++) begin
      do_write(16'hA5A0 + 16'(i));
      if (i < 15) cnt_pulse(3, 4);
    end
    n_tests++;
    if (COUNT_OUT !== 12'd15) begin n_fail++; $display("FAIL wr_final_count: got %0d expected 15", COUNT_OUT); end
    cnt_clear();
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        wait_oe(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL rd_oe_timeout addr 0: got DATA_OE=0 expected 1"); end
      end else begin
        CNT_CLK_IN = 1'b1;
        cyc(3);
        CNT_CLK_IN = 1'b0;
        lat = 0;
        seen_low = 1'b0;
        for (int k = 1; k <= 12; k++) begin
          cyc(1);
          if (!DATA_OE) seen_low = 1'b1;
          else if (seen_low && lat == 0) lat = k;
        end
        n_tests++;
        if (lat != 5) begin n_fail++; $display("FAIL rd_oe_latency addr %0d: got %0d expected 5", i, lat); end
      end
      n_tests++;
      if (DATA_OUT !== 16'hA5A0 + 16'(i)) begin
        n_fail++;
        $display("FAIL rd_data addr %0d: got %h expected %h", i, DATA_OUT, 16'hA5A0 + 16'(i));
      end
      $display("[TB] read count=%0d data=%h", COUNT_OUT, DATA_OUT);
    end
    n_tests++;
    if (WR_COUNT !== 16'd16) begin n_fail++; $display("FAIL rd_wr_count: got %0d expected 16", WR_COUNT); end
    n_tests++;
    if (PROTO_ERR !== 1'b0) begin n_fail++; $display("FAIL rd_proto_err: got %b expected 0", PROTO_ERR); end
  endtask

  task automatic test_wrap();
    bit ok;
    cnt_clear();
    for (int i = 0; i < 4095; i++) cnt_pulse(3, 3);
    n_tests++;
    if (COUNT_OUT !== 12'hFFF) begin n_fail++; $display("FAIL wrap_max: got %h expected fff", COUNT_OUT); end
    CNT_CLK_IN = 1'b1;
    cyc(3);
    CNT_CLK_IN = 1'b0;
    cyc(2);
    n_tests++;
    if (COUNT_OUT !== 12'hFFF) begin n_fail++; $display("FAIL wrap_early: got %h expected fff", COUNT_OUT); end
    cyc(1);
    n_tests++;
    if (COUNT_OUT !== 12'h000) begin n_fail++; $display("FAIL wrap_zero: got %h expected 000", COUNT_OUT); end
    for (int i = 0; i < 17; i++) cnt_pulse(3, 3);
    n_tests++;
    if (COUNT_OUT !== 12'd17) begin n_fail++; $display("FAIL alias_count: got %0d expected 17", COUNT_OUT); end
    wait_oe(ok);
    n_tests++;
    if (!ok || DATA_OUT !== 16'hA5A1) begin
      n_fail++;
      $display("FAIL alias_data: got %h oe=%b expected a5a1", DATA_OUT, DATA_OE);
    end
    $display("[TB] read count=%0d data=%h", COUNT_OUT, DATA_OUT);
  endtask

  task automatic test_turnaround();
    bit ok;
    int drop;
    wait_oe(ok);
    DATA_IN   = 16'h5A5A;
    WE_BAR_IN = 1'b0;
    drop = 0;
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      if (!DATA_OE && drop == 0) drop = k;
    end
    n_tests++;
    if (!ok || drop == 0) begin n_fail++; $display("FAIL turn_oe_drop: got oe=%b after 3 CLK expected 0", DATA_OE); end
    cyc(1);
    n_tests++;
    if (DATA_OE !== 1'b0) begin n_fail++; $display("FAIL turn_oe_hold1: got %b expected 0", DATA_OE); end
    cyc(1);
    n_tests++;
    if (DATA_OE !== 1'b0) begin n_fail++; $display("FAIL turn_oe_hold2: got %b expected 0", DATA_OE); end
    WE_BAR_IN = 1'b1;
    cyc(6);
    $display("[TB] write count=%0d data=5a5a", COUNT_OUT);
    n_tests++;
    if (WR_COUNT !== 16'd17) begin n_fail++; $display("FAIL turn_wr_count: got %0d expected 17", WR_COUNT); end
    n_tests++;
    if (PROTO_ERR !== 1'b0) begin n_fail++; $display("FAIL turn_proto_err: got %b expected 0", PROTO_ERR); end
    wait_oe(ok);
    n_tests++;
    if (!ok || DATA_OUT !== 16'h5A5A) begin n_fail++; $display("FAIL turn_readback: got %h expected 5a5a", DATA_OUT); end
  endtask

  task automatic test_midwrite();
    bit ok;
    DATA_IN   = 16'hBEEF;
    WE_BAR_IN = 1'b0;
    cyc(4);
    cnt_pulse(3, 4);
    WE_BAR_IN = 1'b1;
    cyc(6);
    $display("[TB] write count=%0d data=beef (address moved)", COUNT_OUT);
    n_tests++;
    if (PROTO_ERR !== 1'b1) begin n_fail++; $display("FAIL mid_proto_err: got %b expected 1", PROTO_ERR); end
    n_tests++;
    if (COUNT_OUT !== 12'd18) begin n_fail++; $display("FAIL mid_count: got %0d expected 18", COUNT_OUT); end
    n_tests++;
    if (WR_COUNT !== 16'd18) begin n_fail++; $display("FAIL mid_wr_count: got %0d expected 18", WR_COUNT); end
    wait_oe(ok);
    n_tests++;
    if (!ok || DATA_OUT !== 16'hBEEF) begin n_fail++; $display("FAIL mid_readback: got %h expected beef", DATA_OUT); end
  endtask

  task automatic test_glitch();
    bit ok;
    RST = 1'b1;
    cyc(2);
    n_tests++;
    if (PROTO_ERR !== 1'b0) begin n_fail++; $display("FAIL glitch_err_cleared: got %b expected 0", PROTO_ERR); end
    RST = 1'b0;
    wait_oe(ok);
    n_tests++;
    if (!ok || DATA_OUT !== 16'hA5A0) begin n_fail++; $display("FAIL glitch_mem_survives: got %h expected a5a0", DATA_OUT); end
    DATA_IN   = 16'hDEAD;
    WE_BAR_IN = 1'b0;
    cyc(1);
    WE_BAR_IN = 1'b1;
    cyc(8);
    $display("[TB] glitch count=%0d data=dead", COUNT_OUT);
    n_tests++;
    if (PROTO_ERR !== 1'b1) begin n_fail++; $display("FAIL glitch_proto_err: got %b expected 1", PROTO_ERR); end
    n_tests++;
    if (WR_COUNT !== 16'd0) begin n_fail++; $display("FAIL glitch_wr_count: got %0d expected 0", WR_COUNT); end
    wait_oe(ok);
    n_tests++;
    if (!ok || DATA_OUT !== 16'hA5A0) begin n_fail++; $display("FAIL glitch_mem: got %h expected a5a0", DATA_OUT); end
  endtask

  task automatic test_fault_inj();
    bit ok;
    logic [15:0] exp5;
`ifdef SRAM_RESP_FAULT_INJ_EN
    exp5 = 16'h1235;
`else
    exp5 = 16'h1234;
`endif
    FAULT_ADDR = 12'd5;
    for (int i = 0; i < 5; i++) cnt_pulse(3, 4);
    n_tests++;
    if (COUNT_OUT !== 12'd5) begin n_fail++; $display("FAIL fault_count: got %0d expected 5", COUNT_OUT); end
    do_write(16'h1234);
    n_tests++;
    if (WR_COUNT !== 16'd1) begin n_fail++; $display("FAIL fault_wr_count: got %0d expected 1", WR_COUNT); end
    wait_oe(ok);
    n_tests++;
    if (!ok || DATA_OUT !== exp5) begin n_fail++; $display("FAIL fault_read5: got %h expected %h", DATA_OUT, exp5); end
    $display("[TB] read count=%0d data=%h", COUNT_OUT, DATA_OUT);
    cnt_pulse(3, 4);
    wait_oe(ok);
    n_tests++;
    if (!ok || DATA_OUT !== 16'hA5A6) begin n_fail++; $display("FAIL fault_read6: got %h expected a5a6", DATA_OUT); end
    $display("[TB] read count=%0d data=%h", COUNT_OUT, DATA_OUT);
  endtask

  initial begin
    RST        = 1'b1;
    CNT_CLK_IN = 1'b0;
    CNT_RST_IN = 1'b0;
    WE_BAR_IN  = 1'b1;
    DATA_IN    = 16'h0;
    FAULT_ADDR = 12'hFFF;
    test_reset();
    test_write_readback();
    test_wrap();
    test_turnaround();
    test_midwrite();
    test_glitch();
    test_fault_inj();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation still running at 5 ms, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
